nonce_collector: RTL and testbench
==================================

Name: nonce_collector

Overview:
- Downstream of the miner/odo_keccak compare stage. Consumes the in-order `(has_res, res)` result stream and tags each result with its nonce.
- Queues winning nonces in a small FIFO, so hits arriving close together are not lost, as they would be with a single last-hit register.
- Presents queued nonces on a valid/ready port for the readout/pad_nonce path.
- Also keeps hash and drop statistics for probing.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- INONCE, 0, nonce tagged on the first result after reset or new_work; must match the miner's INONCE.
- CW, 4, width of out_count; equals log2(DEPTH)+1.

Ports:
- clk  in  1  miner clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- has_res  in  1  one-cycle strobe: one compare result per strobe, in nonce order.
- res  in  1  qualified by has_res; 1 = hash below target (hit).
- new_work  in  1  one-cycle pulse: header/target changed; restart tagging and discard stale hits.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  consumer accepts the head this cycle.
- out_nonce  out  32  nonce at the FIFO head.
- out_count  out  CW  number of queued entries, 0..DEPTH.
- dropped  out  16  number of hits lost because the FIFO was full; saturates at 0xFFFF.
- hashes  out  48  total has_res strobes since reset; wraps modulo 2^48.

Behaviour:
- Reset (rst=1 at an edge): tag counter = INONCE; FIFO emptied; out_valid=0, out_nonce=0, out_count=0, dropped=0, hashes=0. Reset overrides every other input.
- Tag counter: increments by 1 on each accepted has_res, whether res is 0 or 1. Wraps 0xFFFFFFFF -> 0x00000000 with no flag.
- Each accepted has_res increments hashes.
- Push: has_res && res pushes the current tag value, i.e. the value before the increment.
- Pop: out_valid && out_ready at an edge removes the head.
- Latency: a push at edge N gives out_valid=1 and the pushed out_nonce from just after edge N, when the FIFO was empty at edge N. Show-ahead FIFO; out_nonce is registered or driven from RAM read-ahead, with no combinational path from has_res.
- Stability: out_nonce and out_valid hold while out_valid && !out_ready. When out_valid=0, out_nonce holds its last value (0 after reset).
- Order: strict FIFO order, equal to nonce order within one work unit.
- Full (out_count == DEPTH):
  - A hit with no pop in the same cycle is discarded and dropped increments (saturating).
  - A hit with a pop in the same cycle is accepted; count stays at DEPTH and dropped is unchanged.
- Empty: out_ready is ignored and there is no underflow. A push into an empty FIFO is never popped in the same cycle.
- Simultaneous push and pop when not full or empty: both occur; count is unchanged.
- new_work=1 at an edge:
  - FIFO flushed (count=0, out_valid=0); tag counter = INONCE.
  - A has_res in the same cycle is ignored for tagging and pushing, but still counted in hashes.
  - A pending pop in the same cycle does not occur; flush wins.
  - dropped is not cleared.
- out_count is always consistent with the pointers; no states beyond the pointers, count, and tag counter are required.

Test Plan:
1. Reset, INONCE=0. Send has_res on 5 cycles with res=0,0,1,0,1; out_ready=0 -> out_count=2, head out_nonce=2, hashes=5. Assert out_ready for 2 cycles -> nonces 2 then 4, then out_valid=0 and out_count=0.
2. Fill with out_ready=0: 10 consecutive hits with DEPTH=8 -> out_count=8, dropped=2. Drain -> nonces 0..7 in order.
3. Full FIFO, hit with out_ready=1 in the same cycle -> count stays 8, dropped unchanged, new tail nonce equals the tag value. Drain confirms it is last.
4. INONCE=0xFFFFFFFE, 3 hits -> queued nonces 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.
5. 3 queued hits, then new_work together with has_res/res=1 and out_ready=1 -> out_valid=0 and count=0 after the edge; hashes incremented. Next hit is tagged INONCE; dropped is unchanged.
6. Assert rst mid-stream with 4 queued and dropped=3 -> all outputs return to their reset values at the next edge. The first hit afterwards is tagged INONCE.

Source files
------------

// File: rtl/nonce_collector.sv
module nonce_collector #(
  parameter int unsigned DEPTH  = 8,
  parameter logic [31:0] INONCE = 32'h0000_0000,
  parameter int unsigned CW     = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          has_res,
  input  logic          res,
  input  logic          new_work,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_nonce,
  output logic [CW-1:0] out_count,
  output logic [15:0]   dropped,
  output logic [47:0]   hashes
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] rd_ptr_nxt;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   tag_q, tag_d;
  logic [31:0]   nonce_q, nonce_d;
  logic [15:0]   dropped_q, dropped_d;
  logic [47:0]   hashes_q, hashes_d;
  logic          hit, empty, full, pop, push;

  always_comb begin
    hit        = has_res && res && !new_work;
    empty      = (count_q == '0);
    full       = (count_q == CW'(DEPTH));
    pop        = !empty && out_ready && !new_work;
    push       = hit && (!full || pop);
    rd_ptr_nxt = rd_ptr_q + AW'(1);

    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    tag_d     = tag_q;
    nonce_d   = nonce_q;
    dropped_d = dropped_q;
    hashes_d  = hashes_q + 48'(has_res);

    if (new_work) begin
      tag_d    = INONCE;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (has_res) tag_d = tag_q + 32'd1;
      if (push)    wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_d = rd_ptr_nxt;
      count_d = count_q + CW'(push) - CW'(pop);
      if (hit && full && !pop && dropped_q != '1)
        dropped_d = dropped_q + 16'd1;
      // Head register is loaded ahead: next stored entry on pop, or the
      // incoming tag when it becomes the new head.
      if (pop && count_q > CW'(1))
        nonce_d = mem_q[rd_ptr_nxt];
      else if (push && (empty || pop))
        nonce_d = tag_q;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= tag_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      tag_q     <= INONCE;
      nonce_q   <= '0;
      dropped_q <= '0;
      hashes_q  <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      tag_q     <= tag_d;
      nonce_q   <= nonce_d;
      dropped_q <= dropped_d;
      hashes_q  <= hashes_d;
    end
  end

  assign out_valid = (count_q != '0);
  assign out_nonce = nonce_q;
  assign out_count = count_q;
  assign dropped   = dropped_q;
  assign hashes    = hashes_q;

endmodule

// File: tb/tb_nonce_collector.sv
module tb_nonce_collector;

  localparam int unsigned DEPTH = 8;
  localparam logic [31:0] OFF   = 32'hFFFF_FFFE;

  logic clk = 1'b0;
  logic rst = 1'b1, has_res = 1'b0, res = 1'b0, new_work = 1'b0, out_ready = 1'b0;
  logic v0, v1;
  logic [31:0] n0, n1;
  logic [3:0] c0, c1;
  logic [15:0] d0, d1;
  logic [47:0] h0, h1;

  nonce_collector #(.DEPTH(DEPTH), .INONCE(32'h0), .CW(4)) dut0 (
    .clk(clk), .rst(rst), .has_res(has_res), .res(res), .new_work(new_work),
    .out_valid(v0), .out_ready(out_ready), .out_nonce(n0), .out_count(c0),
    .dropped(d0), .hashes(h0)
  );

  nonce_collector #(.DEPTH(DEPTH), .INONCE(OFF), .CW(4)) dut1 (
    .clk(clk), .rst(rst), .has_res(has_res), .res(res), .new_work(new_work),
    .out_valid(v1), .out_ready(out_ready), .out_nonce(n1), .out_count(c1),
    .dropped(d1), .hashes(h1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endfunction

  // Reference model: nonces relative to INONCE=0; dut1 differs by a constant offset.
  logic [31:0] mq[$];
  logic [31:0] m_tag, m_last0, m_last1;
  logic [15:0] m_drop;
  logic [47:0] m_hash;
  bit started = 0;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_tag = 0; m_last0 = 0; m_last1 = 0; m_drop = 0; m_hash = 0;
      started = 1;
    end else begin
      if (has_res) m_hash = m_hash + 48'd1;
      if (new_work) begin
        mq.delete();
        m_tag = 0;
      end else begin
        if (mq.size() > 0 && out_ready) void'(mq.pop_front());
        if (has_res && res) begin
          if (mq.size() < DEPTH) mq.push_back(m_tag);
          else if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
        end
        if (has_res) m_tag = m_tag + 32'd1;
      end
      if (mq.size() > 0) begin
        m_last0 = mq[0];
        m_last1 = mq[0] + OFF;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("valid0", v0, mq.size() != 0);
      chk("count0", c0, mq.size());
      chk("nonce0", n0, m_last0);
      chk("dropped0", d0, m_drop);
      chk("hashes0", h0, m_hash);
      chk("valid1", v1, mq.size() != 0);
      chk("count1", c1, mq.size());
      chk("nonce1", n1, m_last1);
      chk("dropped1", d1, m_drop);
      chk("hashes1", h1, m_hash);
    end
  end

  task automatic step(input logic hr, input logic r, input logic nw,
                      input logic rdy, input logic rs);
    has_res = hr; res = r; new_work = nw; out_ready = rdy; rst = rs;
    @(negedge clk);
  endtask

  task automatic do_reset();
    step(0, 0, 0, 0, 1);
  endtask

  logic [31:0] e4 [3];
  int unsigned rdy_pct;

  initial begin
    // 1: mixed results then two pops
    do_reset();
    chk("rst_valid", v0, 0); chk("rst_nonce", n0, 0); chk("rst_count", c0, 0);
    step(1, 0, 0, 0, 0); step(1, 0, 0, 0, 0); step(1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0); step(1, 1, 0, 0, 0);
    chk("t1_count", c0, 2); chk("t1_head", n0, 2); chk("t1_hashes", h0, 5);
    step(0, 0, 0, 1, 0);
    chk("t1_second", n0, 4);
    step(0, 0, 0, 1, 0);
    chk("t1_valid", v0, 0); chk("t1_empty", c0, 0); chk("t1_hold", n0, 4);

    // 2: overflow then drain
    do_reset();
    repeat (10) step(1, 1, 0, 0, 0);
    chk("t2_count", c0, 8); chk("t2_dropped", d0, 2);
    for (int i = 0; i < 8; i++) begin
      chk("t2_drain", n0, i);
      step(0, 0, 0, 1, 0);
    end
    chk("t2_empty", c0, 0);

    // 3: hit while full with simultaneous pop
    do_reset();
    repeat (8) step(1, 1, 0, 0, 0);
    step(1, 1, 0, 1, 0);
    chk("t3_count", c0, 8); chk("t3_dropped", d0, 0); chk("t3_head", n0, 1);
    for (int i = 1; i <= 8; i++) begin
      chk("t3_drain", n0, i);
      step(0, 0, 0, 1, 0);
    end
    chk("t3_valid", v0, 0);

    // 4: tag wrap on the INONCE=0xFFFFFFFE instance
    do_reset();
    repeat (3) step(1, 1, 0, 0, 0);
    e4[0] = 32'hFFFF_FFFE; e4[1] = 32'hFFFF_FFFF; e4[2] = 32'h0000_0000;
    for (int i = 0; i < 3; i++) begin
      chk("t4_wrap", n1, e4[i]);
      step(0, 0, 0, 1, 0);
    end

    // 5: new_work flush with coincident hit and pop
    do_reset();
    repeat (3) step(1, 1, 0, 0, 0);
    step(1, 1, 1, 1, 0);
    chk("t5_valid", v0, 0); chk("t5_count", c0, 0); chk("t5_hashes", h0, 4);
    step(1, 1, 0, 0, 0);
    chk("t5_tag0", n0, 0); chk("t5_tag1", n1, 32'hFFFF_FFFE);
    chk("t5_count1", c0, 1); chk("t5_dropped", d0, 0);

    // 6: reset mid-stream
    do_reset();
    repeat (11) step(1, 1, 0, 0, 0);
    chk("t6_dropped", d0, 3);
    repeat (4) step(0, 0, 0, 1, 0);
    chk("t6_count", c0, 4);
    step(1, 1, 1, 1, 1);
    chk("t6_valid", v0, 0); chk("t6_nonce", n0, 0); chk("t6_count0", c0, 0);
    chk("t6_drop0", d0, 0); chk("t6_hash0", h0, 0); chk("t6_nonce1", n1, 0);
    step(1, 1, 0, 0, 0);
    chk("t6_tag0", n0, 0); chk("t6_tag1", n1, 32'hFFFF_FFFE);

    // randomized traffic with varying consumer throughput
    for (int b = 0; b < 20; b++) begin
      rdy_pct = $urandom_range(5, 70);
      for (int k = 0; k < 200; k++) begin
        step($urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1,
             $urandom_range(0, 59) == 0, $urandom_range(0, 99) < rdy_pct,
             $urandom_range(0, 299) == 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
